// File: rtl/layer0_pkg.sv
// Shared definitions for the layer0 feature quantizer: code width, FSM states
// and default signed thresholds.
package layer0_pkg;

    localparam int QCODE_W = 2;

    localparam int THR_LO_DEF  = -100;
    localparam int THR_MID_DEF = 0;
    localparam int THR_HI_DEF  = 100;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        RESYNC  = 2'd2
    } state_e;

endpackage

// File: rtl/feature_quant.sv
// Purely combinational 4-level quantizer: maps one signed sample onto a
// 2-bit code using three signed thresholds.
module feature_quant
    import layer0_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int THR_LO   = THR_LO_DEF,
    parameter int THR_MID  = THR_MID_DEF,
    parameter int THR_HI   = THR_HI_DEF
) (
    input  logic signed [SAMPLE_W-1:0] sample_i,
    output logic        [QCODE_W-1:0]  code_o
);

    int sample_ext;

    // Widening to int keeps the comparison signed against the int thresholds.
    assign sample_ext = int'(sample_i);

    always_comb begin
        if (sample_ext < THR_LO) begin
            code_o = 2'b00;
        end else if (sample_ext < THR_MID) begin
            code_o = 2'b01;
        end else if (sample_ext < THR_HI) begin
            code_o = 2'b10;
        end else begin
            code_o = 2'b11;
        end
    end

endmodule

// File: rtl/layer0_feature_quantizer.sv
// Collects NUM_FEAT quantized samples per frame into a packed feature vector,
// checks frame alignment and hands the vector to layer0 over a valid/ready link.
module layer0_feature_quantizer
    import layer0_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int NUM_FEAT = 8,
    parameter int THR_LO   = THR_LO_DEF,
    parameter int THR_MID  = THR_MID_DEF,
    parameter int THR_HI   = THR_HI_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SAMPLE_W-1:0]            s_data,
    input  logic                           s_valid,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic [QCODE_W*NUM_FEAT-1:0]    m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           err_align
);

    localparam int                VEC_W    = QCODE_W * NUM_FEAT;
    localparam int                CNT_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_FEAT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [VEC_W-1:0]   coll_q;
    logic [VEC_W-1:0]   coll_d;
    logic [VEC_W-1:0]   m_data_q;
    logic               m_valid_q;
    logic               s_ready_q;
    logic               err_q;
    logic [QCODE_W-1:0] code;
    logic               accept;
    logic               out_hs;
    logic               out_free;

    feature_quant #(
        .SAMPLE_W (SAMPLE_W),
        .THR_LO   (THR_LO),
        .THR_MID  (THR_MID),
        .THR_HI   (THR_HI)
    ) u_quant (
        .sample_i (s_data),
        .code_o   (code)
    );

    assign accept   = s_valid && s_ready_q;
    assign out_hs   = m_valid_q && m_ready;
    assign out_free = !m_valid_q || m_ready;

    // NOTE: every signal written in always_comb gets a full default first, so no latch is inferred.
    always_comb begin
        coll_d = coll_q;
        coll_d[QCODE_W*int'(cnt_q) +: QCODE_W] = code;
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register including the vector storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            coll_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_hs) begin
                m_valid_q <= 1'b0;
            end
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_q <= '0;
                            if (!s_last) begin
                                err_q   <= 1'b1;
                                coll_q  <= '0;
                                state_q <= RESYNC;
                            end else if (out_free) begin
                                m_data_q  <= coll_d;
                                m_valid_q <= 1'b1;
                                coll_q    <= '0;
                            end else begin
                                // Output still busy: park the finished vector and stall input.
                                coll_q    <= coll_d;
                                s_ready_q <= 1'b0;
                                state_q   <= HOLD;
                            end
                        end else if (s_last) begin
                            err_q  <= 1'b1;
                            cnt_q  <= '0;
                            coll_q <= '0;
                        end else begin
                            coll_q <= coll_d;
                            cnt_q  <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_hs) begin
                        m_data_q  <= coll_q;
                        m_valid_q <= 1'b1;
                        coll_q    <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= COLLECT;
                    end
                end
                RESYNC: begin
                    if (accept && s_last) begin
                        cnt_q   <= '0;
                        state_q <= COLLECT;
                    end
                end
                default: begin
                    state_q   <= COLLECT;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign err_align = err_q;

endmodule

// File: tb/tb_layer0_feature_quantizer.sv
// Directed self-checking bench for layer0_feature_quantizer with hand-computed
// feature vectors for good, backpressured, misaligned, reset and streaming frames.
module tb_layer0_feature_quantizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        err_align;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_cnt  = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          hs_cyc_q[$];

    // Frame A: codes f0..f7 = 00 01 10 11 01 10 11 10 -> 16'hB9E4
    int frame_a[8] = '{-200, -50, 50, 200, -100, 0, 100, 99};
    // Frame B: codes f0..f7 = 10 11 01 00 10 01 11 00 -> 16'h361E
    int frame_b[8] = '{99, 100, -1, -101, 0, -100, 101, -32768};
    localparam logic [15:0] VEC_A = 16'b10_11_10_01_11_10_01_00;
    localparam logic [15:0] VEC_B = 16'b00_11_01_10_00_01_11_10;

    layer0_feature_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .err_align (err_align)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so negedge values hold through the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                hs_cyc_q.push_back(cyc);
            end
            if (err_align) err_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int v, input logic last);
        int budget = 0;
        s_data  = 16'(v);
        s_valid = 1'b1;
        s_last  = last;
        while (!s_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!s_ready) check("ready_timeout", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic sel_b);
        for (int j = 0; j < 8; j++) send(sel_b ? frame_b[j] : frame_a[j], j == 7);
    endtask

    task automatic compare_got(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_vec"}, {16'd0, got_q[i]}, {16'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int e0;
        int c0;

        #12;
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_err", {31'd0, err_align}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame
        m_ready = 1'b1;
        e0 = err_cnt;
        for (int j = 0; j < 8; j++) begin
            send(frame_a[j], j == 7);
            if (j == 6) check("good_no_early_valid", {31'd0, m_valid}, 32'd0);
        end
        check("good_valid", {31'd0, m_valid}, 32'd1);
        check("good_data", {16'd0, m_data}, {16'd0, VEC_A});
        idle(1);
        check("good_valid_drop", {31'd0, m_valid}, 32'd0);
        check("good_no_err", err_cnt - e0, 0);
        exp_q.push_back(VEC_A);
        compare_got("good");

        // Backpressure: two frames, second must park in HOLD
        m_ready = 1'b0;
        send_frame(1'b0);
        send_frame(1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
        check("bp_state_hold", {30'd0, dut.state_q}, 32'd1);
        check("bp_valid", {31'd0, m_valid}, 32'd1);
        check("bp_data_f1", {16'd0, m_data}, {16'd0, VEC_A});
        idle(3);
        check("bp_data_stable", {16'd0, m_data}, {16'd0, VEC_A});
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_data_f2", {16'd0, m_data}, {16'd0, VEC_B});
        check("bp_s_ready_back", {31'd0, s_ready}, 32'd1);
        idle(2);
        check("bp_valid_drop", {31'd0, m_valid}, 32'd0);
        exp_q.push_back(VEC_A);
        exp_q.push_back(VEC_B);
        compare_got("bp");

        // Short frame
        e0 = err_cnt;
        for (int j = 0; j < 5; j++) send(frame_a[j], j == 4);
        check("short_err_pulse", {31'd0, err_align}, 32'd1);
        idle(1);
        check("short_err_clear", {31'd0, err_align}, 32'd0);
        check("short_err_count", err_cnt - e0, 1);
        check("short_no_valid", got_q.size(), 0);
        send_frame(1'b1);
        idle(2);
        exp_q.push_back(VEC_B);
        compare_got("short_next");

        // Long frame
        e0 = err_cnt;
        for (int j = 0; j < 12; j++) begin
            send(frame_b[j % 8], j == 11);
            if (j == 7) check("long_err_at8", {31'd0, err_align}, 32'd1);
        end
        idle(2);
        check("long_err_count", err_cnt - e0, 1);
        check("long_no_valid", got_q.size(), 0);
        send_frame(1'b0);
        idle(2);
        exp_q.push_back(VEC_A);
        compare_got("long_next");

        // Reset mid-frame with a vector pending at the output
        m_ready = 1'b0;
        send_frame(1'b1);
        for (int j = 0; j < 3; j++) send(frame_a[j], 1'b0);
        s_valid = 1'b0;
        check("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_m_data", {16'd0, m_data}, 32'd0);
        check("arst_s_ready", {31'd0, s_ready}, 32'd1);
        check("arst_err", {31'd0, err_align}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete();
        m_ready = 1'b1;
        send_frame(1'b0);
        idle(2);
        exp_q.push_back(VEC_A);
        compare_got("after_rst");

        // Streaming: four back-to-back frames
        hs_cyc_q.delete();
        e0 = err_cnt;
        c0 = cyc;
        send_frame(1'b0);
        send_frame(1'b1);
        send_frame(1'b0);
        send_frame(1'b1);
        check("stream_no_bubble", cyc - c0, 32);
        idle(3);
        check("stream_hs_count", hs_cyc_q.size(), 4);
        for (int i = 1; i < hs_cyc_q.size(); i++)
            check("stream_spacing", hs_cyc_q[i] - hs_cyc_q[i-1], 8);
        check("stream_no_err", err_cnt - e0, 0);
        exp_q.push_back(VEC_A);
        exp_q.push_back(VEC_B);
        exp_q.push_back(VEC_A);
        exp_q.push_back(VEC_B);
        compare_got("stream");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
